demux_route_hs: RTL and testbench

//  Registered 1-to-NCH demultiplexer with valid/ready handshake; inverse of the datapath selectors.

---
 rtl/mips_bus_pkg.sv | 16 +
 rtl/sat_counter.sv | 22 ++
 rtl/demux_route_hs.sv | 86 ++++++++
 tb/tb_demux_route_hs.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_bus_pkg.sv
// Shared widths and channel indices for the MEM-stage store-data bus.
// The select-legality helper is shared by the router and its bench.
package mips_bus_pkg;
  localparam int BUS_DW   = 32;
  localparam int SELW     = 2;
  localparam int BUS_CNTW = 16;
  localparam int BUS_NCH  = 3;

  localparam int CH_DMEM = 0;
  localparam int CH_IO0  = 1;
  localparam int CH_IO1  = 2;

  function automatic logic sel_legal(input logic [SELW-1:0] sel, input int nch);
    return int'(sel) < nch;
  endfunction
endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
// It advances by one on each cycle in which inc is high.
module sat_counter #(
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inc,
  output logic [CNTW-1:0] cnt
);
  logic [CNTW-1:0] cnt_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (inc && (cnt_reg != '1)) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign cnt = cnt_reg;
endmodule

// File: rtl/demux_route_hs.sv
// Registered 1-to-NCH word router with valid/ready handshake, one-entry output stage,
// saturating per-channel transfer counters and an invalid-select drop counter.
module demux_route_hs
  import mips_bus_pkg::*;
#(
  parameter int DW   = BUS_DW,
  parameter int NCH  = BUS_NCH,
  parameter int CNTW = BUS_CNTW
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DW-1:0]       in_data,
  input  logic [SELW-1:0]     in_sel,
  output logic [NCH-1:0]      out_valid,
  input  logic [NCH-1:0]      out_ready,
  output logic [NCH*DW-1:0]   out_data,
  output logic                err_pulse,
  output logic [NCH*CNTW-1:0] xfer_cnt,
  output logic [CNTW-1:0]     err_cnt
);
  logic            valid_reg;
  logic [SELW-1:0] sel_reg;
  logic [DW-1:0]   data_reg;
  logic            err_reg;

  logic [(1<<SELW)-1:0] ready_pad;
  logic                 sel_ok;
  logic                 drain;
  logic                 accept;
  logic                 drop;

  // Pad ready to the full select range so an index of any select value is legal.
  always_comb begin
    ready_pad              = '0;
    ready_pad[NCH-1:0]     = out_ready;
  end

  assign sel_ok   = sel_legal(in_sel, NCH);
  assign drain    = valid_reg & ready_pad[sel_reg];
  assign in_ready = ~valid_reg | ready_pad[sel_reg];
  assign accept   = in_valid & in_ready & sel_ok;
  assign drop     = in_valid & in_ready & ~sel_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_reg <= 1'b0;
      sel_reg   <= '0;
      data_reg  <= '0;
      err_reg   <= 1'b0;
    end else begin
      valid_reg <= accept | (valid_reg & ~drain);
      err_reg   <= drop;
      if (accept) begin
        sel_reg  <= in_sel;
        data_reg <= in_data;
      end
    end
  end

  assign err_pulse = err_reg;

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
      logic sel_hit;
      assign sel_hit                    = (sel_reg == SELW'(gi));
      assign out_valid[gi]              = valid_reg & sel_hit;
      assign out_data[gi*DW +: DW]      = sel_hit ? data_reg : '0;

      sat_counter #(.CNTW(CNTW)) u_xfer_cnt (
        .clk (clk),
        .rst (rst),
        .inc (drain & sel_hit),
        .cnt (xfer_cnt[gi*CNTW +: CNTW])
      );
    end
  endgenerate

  sat_counter #(.CNTW(CNTW)) u_err_cnt (
    .clk (clk),
    .rst (rst),
    .inc (drop),
    .cnt (err_cnt)
  );
endmodule

// File: tb/tb_demux_route_hs.sv
// Scoreboard bench for demux_route_hs with NCH=3 and 4-bit counters so saturation is reachable.
// Inputs change and outputs are sampled on the falling edge.
module tb_demux_route_hs;
  import mips_bus_pkg::*;

  localparam int DW   = 32;
  localparam int NCH  = 3;
  localparam int CNTW = 4;
  localparam int CMAX = (1 << CNTW) - 1;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic [DW-1:0]       in_data;
  logic [SELW-1:0]     in_sel;
  logic [NCH-1:0]      out_valid;
  logic [NCH-1:0]      out_ready;
  logic [NCH*DW-1:0]   out_data;
  logic                err_pulse;
  logic [NCH*CNTW-1:0] xfer_cnt;
  logic [CNTW-1:0]     err_cnt;

  typedef struct {
    logic [SELW-1:0] sel;
    logic [DW-1:0]   data;
  } word_t;

  word_t exp_q[$];
  int    exp_xfer[NCH];
  int    exp_err;
  int    n_checks;
  int    n_fail;

  always #5 clk = ~clk;

  demux_route_hs #(.DW(DW), .NCH(NCH), .CNTW(CNTW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_sel    (in_sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .err_pulse (err_pulse),
    .xfer_cnt  (xfer_cnt),
    .err_cnt   (err_cnt)
  );

  function automatic logic [DW-1:0] chdata(input int k);
    return out_data[k*DW +: DW];
  endfunction

  function automatic int cnt(input int k);
    return int'(xfer_cnt[k*CNTW +: CNTW]);
  endfunction

  function automatic logic [NCH-1:0] onehot(input logic [SELW-1:0] s);
    logic [NCH-1:0] v;
    v = '0;
    v[s] = 1'b1;
    return v;
  endfunction

  // Model update for a word drained at the coming rising edge.
  task automatic note_drain(input logic [SELW-1:0] s);
    if (exp_xfer[s] < CMAX) exp_xfer[s]++;
  endtask

  task automatic push_word(input logic [SELW-1:0] s, input logic [DW-1:0] d);
    word_t w;
    w.sel = s;
    w.data = d;
    exp_q.push_back(w);
    in_valid = 1'b1;
    in_sel   = s;
    in_data  = d;
  endtask

  task automatic test_reset();
    @(negedge clk);
    push_word(2'(CH_DMEM), 32'h0BAD_F00D);
    out_ready = '0;
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if (out_valid !== 3'b001) begin
      n_fail++; $display("FAIL reset_hold out_valid=%b required=%b", out_valid, 3'b001);
    end
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    exp_q.delete();
    foreach (exp_xfer[k]) exp_xfer[k] = 0;
    exp_err = 0;
    n_checks++;
    if (out_valid !== '0) begin
      n_fail++; $display("FAIL reset_async_valid out_valid=%b required=0", out_valid);
    end
    n_checks++;
    if (out_data !== '0) begin
      n_fail++; $display("FAIL reset_async_data out_data=%h required=0", out_data);
    end
    n_checks++;
    if (xfer_cnt !== '0 || err_cnt !== '0) begin
      n_fail++; $display("FAIL reset_counters xfer_cnt=%h err_cnt=%h required=0", xfer_cnt, err_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_in_ready in_ready=%b required=1", in_ready);
    end
    n_checks++;
    if (err_pulse !== 1'b0) begin
      n_fail++; $display("FAIL reset_err_pulse err_pulse=%b required=0", err_pulse);
    end
    $display("reset: held word discarded");
  endtask

  task automatic test_single();
    word_t w;
    @(negedge clk);
    out_ready = 3'b010;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL single_in_ready in_ready=%b required=1", in_ready);
    end
    push_word(2'(CH_IO0), 32'hDEAD_BEEF);
    @(negedge clk);
    in_valid = 1'b0;
    w = exp_q.pop_front();
    n_checks++;
    if (out_valid !== onehot(w.sel)) begin
      n_fail++; $display("FAIL single_valid out_valid=%b required=%b", out_valid, onehot(w.sel));
    end
    n_checks++;
    if (chdata(1) !== w.data || chdata(0) !== '0 || chdata(2) !== '0) begin
      n_fail++; $display("FAIL single_data ch0=%h ch1=%h ch2=%h required=0/%h/0",
                         chdata(0), chdata(1), chdata(2), w.data);
    end
    note_drain(w.sel);
    $display("xfer ch%0d data %h", w.sel, w.data);
    @(negedge clk);
    n_checks++;
    if (cnt(1) !== exp_xfer[1] || out_valid !== '0) begin
      n_fail++; $display("FAIL single_count xfer1=%0d out_valid=%b required=%0d/000",
                         cnt(1), out_valid, exp_xfer[1]);
    end
  endtask

  task automatic test_backpressure();
    word_t w;
    @(negedge clk);
    out_ready = 3'b011;  // non-selected readies must be ignored
    push_word(2'(CH_IO1), 32'hA5A5_5A5A);
    @(negedge clk);
    w = exp_q.pop_front();
    in_valid = 1'b1;
    in_sel   = 2'(CH_DMEM);
    in_data  = 32'h1234_5678;
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (in_ready !== 1'b0) begin
        n_fail++; $display("FAIL bp_in_ready cycle=%0d in_ready=%b required=0", i, in_ready);
      end
      n_checks++;
      if (out_valid !== onehot(w.sel) || chdata(2) !== w.data) begin
        n_fail++; $display("FAIL bp_hold cycle=%0d out_valid=%b ch2=%h required=%b/%h",
                           i, out_valid, chdata(2), onehot(w.sel), w.data);
      end
      @(negedge clk);
    end
    out_ready = 3'b100;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL bp_release in_ready=%b required=1", in_ready);
    end
    push_word(2'(CH_DMEM), 32'h1234_5678);
    note_drain(w.sel);
    $display("xfer ch%0d data %h", w.sel, w.data);
    @(negedge clk);
    in_valid = 1'b0;
    w = exp_q.pop_front();
    n_checks++;
    if (out_valid !== onehot(w.sel) || chdata(0) !== w.data || chdata(2) !== '0) begin
      n_fail++; $display("FAIL bp_reload out_valid=%b ch0=%h ch2=%h required=%b/%h/0",
                         out_valid, chdata(0), chdata(2), onehot(w.sel), w.data);
    end
    out_ready = 3'b001;
    note_drain(w.sel);
    $display("xfer ch%0d data %h", w.sel, w.data);
    @(negedge clk);
    n_checks++;
    if (cnt(0) !== exp_xfer[0] || cnt(2) !== exp_xfer[2] || out_valid !== '0) begin
      n_fail++; $display("FAIL bp_counts xfer0=%0d xfer2=%0d out_valid=%b required=%0d/%0d/000",
                         cnt(0), cnt(2), out_valid, exp_xfer[0], exp_xfer[2]);
    end
  endtask

  task automatic test_streaming();
    word_t w;
    logic [SELW-1:0] sels[8] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2, 2'd0, 2'd1};
    out_ready = 3'b111;
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      if (i > 0) begin
        w = exp_q.pop_front();
        n_checks++;
        if (out_valid !== onehot(w.sel) || chdata(int'(w.sel)) !== w.data) begin
          n_fail++; $display("FAIL stream_word idx=%0d out_valid=%b data=%h required=%b/%h",
                             i - 1, out_valid, chdata(int'(w.sel)), onehot(w.sel), w.data);
        end
        note_drain(w.sel);
        $display("xfer ch%0d data %h", w.sel, w.data);
      end
      if (i < 8) begin
        n_checks++;
        if (in_ready !== 1'b1) begin
          n_fail++; $display("FAIL stream_in_ready idx=%0d in_ready=%b required=1", i, in_ready);
        end
        push_word(sels[i], 32'hC0DE_0000 + 32'(i));
      end else begin
        in_valid = 1'b0;
      end
    end
    @(negedge clk);
    for (int k = 0; k < NCH; k++) begin
      n_checks++;
      if (cnt(k) !== exp_xfer[k]) begin
        n_fail++; $display("FAIL stream_count ch=%0d xfer=%0d required=%0d", k, cnt(k), exp_xfer[k]);
      end
    end
  endtask

  task automatic test_invalid_sel();
    @(negedge clk);
    out_ready = 3'b111;
    n_checks++;
    if (in_ready !== 1'b1) begin
      n_fail++; $display("FAIL inv_in_ready in_ready=%b required=1", in_ready);
    end
    in_valid = 1'b1;
    in_sel   = 2'd3;
    in_data  = 32'h1;
    if (!sel_legal(in_sel, NCH)) exp_err++;
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if (err_pulse !== 1'b1 || out_valid !== '0) begin
      n_fail++; $display("FAIL inv_pulse err_pulse=%b out_valid=%b required=1/000", err_pulse, out_valid);
    end
    n_checks++;
    if (int'(err_cnt) !== exp_err) begin
      n_fail++; $display("FAIL inv_err_cnt err_cnt=%0d required=%0d", err_cnt, exp_err);
    end
    $display("drop sel 3 data %h", 32'h1);
    @(negedge clk);
    n_checks++;
    if (err_pulse !== 1'b0 || out_valid !== '0) begin
      n_fail++; $display("FAIL inv_pulse_end err_pulse=%b out_valid=%b required=0/000", err_pulse, out_valid);
    end
  endtask

  task automatic test_saturation();
    word_t w;
    out_ready = 3'b001;
    for (int i = 0; i <= 20; i++) begin
      @(negedge clk);
      if (i > 0) begin
        w = exp_q.pop_front();
        n_checks++;
        if (out_valid !== onehot(w.sel) || chdata(0) !== w.data) begin
          n_fail++; $display("FAIL sat_word idx=%0d out_valid=%b ch0=%h required=%b/%h",
                             i - 1, out_valid, chdata(0), onehot(w.sel), w.data);
        end
        note_drain(w.sel);
        $display("xfer ch%0d data %h", w.sel, w.data);
      end
      if (i < 20) push_word(2'(CH_DMEM), 32'(i + 100));
      else in_valid = 1'b0;
    end
    @(negedge clk);
    n_checks++;
    if (cnt(0) !== exp_xfer[0] || cnt(1) !== exp_xfer[1] || cnt(2) !== exp_xfer[2]) begin
      n_fail++; $display("FAIL sat_count xfer=%0d/%0d/%0d required=%0d/%0d/%0d",
                         cnt(0), cnt(1), cnt(2), exp_xfer[0], exp_xfer[1], exp_xfer[2]);
    end
    n_checks++;
    if (cnt(0) !== CMAX) begin
      n_fail++; $display("FAIL sat_max xfer0=%0d required=%0d", cnt(0), CMAX);
    end
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    exp_err   = 0;
    foreach (exp_xfer[k]) exp_xfer[k] = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_sel    = '0;
    in_data   = '0;
    out_ready = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    test_reset();
    test_single();
    test_backpressure();
    test_streaming();
    test_invalid_sel();
    test_saturation();
    test_reset();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
